exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter DATA_W, default 8: register and result width.
REQ-002 Parameter ZERO_REG, default 1: 1 = R0 reads as 0 and writes to R0 are discarded; 0 = R0 is a normal register.
REQ-003 Port clk, input, 1: clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port cmd_valid, input, 1: a command is offered.
REQ-006 Port cmd_ready, output, 1: the unit accepts a command this cycle.
REQ-007 Port cmd_op, input, 2: 00 ONE, 01 ADD, 10 SUB, 11 SWAP.
REQ-008 Port cmd_addr_a, input, 3: destination/first operand register index.
REQ-009 Port cmd_addr_b, input, 3: second operand register index.
REQ-010 Port rsp_valid, output, 1: a result is available.
REQ-011 Port rsp_ready, input, 1: the consumer takes the result.
REQ-012 Port rsp_data, output, DATA_W: computed result.
REQ-013 Port rsp_zero, output, 1: computed result == 0.
REQ-014 Port rsp_carry, output, 1: carry/borrow flag.
REQ-015 Port busy, output, 1: the unit is not in IDLE.
REQ-016 Port dbg_addr / dbg_data, input 3 / output DATA_W: combinational register peek.

Function
REQ-017 Register file: 8 x DATA_W registers, R0..R7.
REQ-018 States: IDLE, READ, EXEC, WR_A, WR_B, RESP.
REQ-019 cmd_ready SHALL be 1 exactly when state == IDLE; busy SHALL be its inverse.
REQ-020 IDLE->READ on cmd_valid && cmd_ready; op, addr_a and addr_b are latched at this edge, and later changes on cmd_* SHALL be ignored.
REQ-021 READ->EXEC: latch opA = R[addr_a] and opB = R[addr_b], applying the R0 rule.
REQ-022 EXEC->WR_A: latch result and flags.
  ONE: res = opA+1; carry = (opA == all ones).
  ADD: {carry,res} = opA+opB, DATA_W+1 bits.
  SUB: res = opA-opB modulo 2^DATA_W; carry = borrow = (opA < opB), unsigned.
  SWAP: res = opB; carry = 0.
  zero = (res == 0) for all ops.
REQ-023 WR_A: R[addr_a] <= res; next state is WR_B if op == SWAP, else RESP.
REQ-024 WR_B (SWAP only): R[addr_b] <= opA; next state RESP.
REQ-025 Latency: rsp_valid SHALL rise 3 edges after the accept edge, or 4 edges for SWAP.
REQ-026 RESP: rsp_valid = 1; rsp_data/zero/carry are held stable until rsp_valid && rsp_ready, then the state returns to IDLE.
REQ-027 rsp_valid SHALL be 0 in all states other than RESP.
REQ-028 Minimum command spacing: the next command is accepted no earlier than the edge after the response handshake; there is no overlap.
REQ-029 With ZERO_REG=1, a write to R0 SHALL be discarded, but rsp_data/flags SHALL still report the computed res.
REQ-030 SWAP with addr_a == addr_b SHALL leave the register unchanged and report res = that value.
REQ-031 Operands are sampled in READ, so results SHALL use register values from before this command's writes.
REQ-032 dbg_data = R[dbg_addr] combinationally, honouring the R0 rule, and reflects writes the cycle after the write edge.
REQ-033 An unknown state encoding SHALL return to IDLE.

Reset
REQ-034 While rst = 1: state = IDLE, all R[i] = 0, latched result/flags = 0, rsp_valid = 0, rsp_data = 0, rsp_zero = 0, rsp_carry = 0, busy = 0, cmd_ready = 1.
REQ-035 rst asserted mid-operation (READ..RESP) SHALL abort without completing any pending write and without producing a response.

Verification
REQ-036 After reset, preload R1=0x05 and R2=0x03; ADD a=1,b=2 -> rsp_valid 3 edges after accept; rsp_data=0x08, zero=0, carry=0; R1=0x08.
REQ-037 R1=0xF0, R2=0x20, ADD a=1,b=2 -> rsp_data=0x10, carry=1; SUB a=2,b=1 (R2=0x20, R1=0x10) -> rsp_data=0x10, carry=0; SUB with R1<R2 -> borrow carry=1.
REQ-038 R3=0xAA, R4=0x55, SWAP a=3,b=4 -> rsp_valid 4 edges after accept; R3=0x55, R4=0xAA, rsp_data=0x55.
REQ-039 ZERO_REG=1: ONE a=0 -> rsp_data=0x01, R0 still reads 0x00; ONE on R5=0xFF -> rsp_data=0x00, zero=1, carry=1.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, cmd_ready=0, a second cmd_valid is not accepted; raise rsp_ready -> IDLE on the next edge.
REQ-041 Assert rst while in EXEC of ADD a=1 -> all registers 0, rsp_valid never rises, cmd_ready=1 after rst falls.

Source files
------------

// File: rtl/exec_unit.sv
// Multi-cycle register-file execution unit: accepts one command at a time,
// reads two operands, computes ONE/ADD/SUB/SWAP, writes back, then holds a response.
module exec_unit #(
    parameter int DATA_W   = 8,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_addr_a,
    input  logic [2:0]        cmd_addr_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              busy,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WR_A = 3'd3,
        S_WR_B = 3'd4,
        S_RESP = 3'd5
    } state_t;

    localparam logic [1:0] OP_ONE  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_op;
    logic [2:0]        r_addr_a;
    logic [2:0]        r_addr_b;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_res;
    logic              r_zero;
    logic              r_carry;
    logic [DATA_W-1:0] r_regs [8];

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_res;
    logic              w_carry;
    logic              w_accept;

    // R0 hard-wired to zero when ZERO_REG is set: reads give 0, writes are dropped.
    function automatic logic is_zero_reg(input logic [2:0] addr);
        return (ZERO_REG != 1'b0) && (addr == 3'd0);
    endfunction

    function automatic logic [DATA_W-1:0] rd_reg(input logic [2:0] addr);
        return is_zero_reg(addr) ? '0 : r_regs[addr];
    endfunction

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_res;
    assign rsp_zero  = r_zero;
    assign rsp_carry = r_carry;
    assign dbg_data  = rd_reg(dbg_addr);
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_READ;
            S_READ: w_next = S_EXEC;
            S_EXEC: w_next = S_WR_A;
            S_WR_A: w_next = (r_op == OP_SWAP) ? S_WR_B : S_RESP;
            S_WR_B: w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Carry of ONE/ADD and borrow of SUB both fall out of the extra top bit.
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_carry = 1'b0;
        case (r_op)
            OP_ONE: begin
                w_sum   = {1'b0, r_opa} + (DATA_W+1)'(1);
                w_res   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
            end
            OP_ADD: begin
                w_sum   = {1'b0, r_opa} + {1'b0, r_opb};
                w_res   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_sum   = {1'b0, r_opa} - {1'b0, r_opb};
                w_res   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
            end
            default: begin
                w_res   = r_opb;
                w_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_res    <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_op     <= cmd_op;
                r_addr_a <= cmd_addr_a;
                r_addr_b <= cmd_addr_b;
            end
            if (r_state == S_READ) begin
                r_opa <= rd_reg(r_addr_a);
                r_opb <= rd_reg(r_addr_b);
            end
            if (r_state == S_EXEC) begin
                r_res   <= w_res;
                r_zero  <= (w_res == '0);
                r_carry <= w_carry;
            end
        end
    end

    // SWAP with a == b writes opB then opA, both equal to the original value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            if (r_state == S_WR_A && !is_zero_reg(r_addr_a))
                r_regs[r_addr_a] <= r_res;
            if (r_state == S_WR_B && !is_zero_reg(r_addr_b))
                r_regs[r_addr_b] <= r_opa;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Randomized self-checking bench for exec_unit against a register-array model.
module tb_exec_unit;

    localparam logic [1:0] ONE = 2'b00, ADD = 2'b01, SUB = 2'b10, SWAP = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_addr_a;
    logic [2:0] cmd_addr_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_carry;
    logic       busy;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    exec_unit #(.DATA_W(8), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int m_reg [8];
    logic [7:0] l_data;
    logic       l_zero, l_carry;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rd(input int a);
        return (a == 0) ? 0 : m_reg[a];
    endfunction

    task automatic chk_dbg(input int a, input int exp);
        dbg_addr = 3'(a);
        #1;
        chk($sformatf("dbg R%0d", a), int'(dbg_data), exp);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk($sformatf("%s R%0d", tag, i), int'(dbg_data), rd(i));
        end
    endtask

    // Issues one command, checks latency/result/flags, holds rsp_ready low for
    // 'hold' cycles (optionally offering a bogus command), then updates the model.
    task automatic do_cmd(input logic [1:0] op, input int a, input int b,
                          input int hold, input bit poke);
        int opa, opb, res, cy, lat, exp_lat, d0;
        opa = rd(a);
        opb = rd(b);
        case (op)
            ONE:  begin res = (opa + 1) % 256;   cy = (opa == 255) ? 1 : 0; end
            ADD:  begin res = (opa + opb) % 256; cy = (opa + opb > 255) ? 1 : 0; end
            SUB:  begin res = (opa - opb + 256) % 256; cy = (opa < opb) ? 1 : 0; end
            default: begin res = opb; cy = 0; end
        endcase
        exp_lat = (op == SWAP) ? 4 : 3;

        chk("cmd_ready idle", int'(cmd_ready), 1);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_addr_a = 3'(a);
        cmd_addr_b = 3'(b);
        rsp_ready  = (hold == 0);
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'($urandom);
        cmd_addr_a = 3'($urandom);
        cmd_addr_b = 3'($urandom);

        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        if (!rsp_valid) return;
        chk("rsp_data", int'(rsp_data), res);
        chk("rsp_zero", int'(rsp_zero), (res == 0) ? 1 : 0);
        chk("rsp_carry", int'(rsp_carry), cy);
        l_data  = rsp_data;
        l_zero  = rsp_zero;
        l_carry = rsp_carry;
        d0 = int'(rsp_data);

        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                cmd_valid  = 1'b1;
                cmd_op     = ONE;
                cmd_addr_a = 3'd7;
                cmd_addr_b = 3'd7;
            end
            @(posedge clk); #1;
            chk("hold rsp_valid", int'(rsp_valid), 1);
            chk("hold rsp_data", int'(rsp_data), d0);
            chk("hold cmd_ready", int'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post-rsp busy", int'(busy), 0);
        chk("post-rsp rsp_valid", int'(rsp_valid), 0);

        if (a != 0) m_reg[a] = res;
        if (op == SWAP && b != 0) m_reg[b] = opa;
        chk_dbg(a, rd(a));
        chk_dbg(b, rd(b));
    endtask

    // Builds an arbitrary value in Rk by clearing it, then shift-and-increment.
    task automatic load_reg(input int k, input int v);
        do_cmd(SUB, k, k, 0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            do_cmd(ADD, k, k, 0, 1'b0);
            if ((v >> i) & 1) do_cmd(ONE, k, k, 0, 1'b0);
        end
        chk_dbg(k, v);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_addr_a = '0; cmd_addr_b = '0;
        rsp_ready = 1'b1; dbg_addr = '0;
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst cmd_ready", int'(cmd_ready), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst rsp_valid", int'(rsp_valid), 0);
        chk("rst rsp_data", int'(rsp_data), 0);
        chk("rst rsp_zero", int'(rsp_zero), 0);
        chk("rst rsp_carry", int'(rsp_carry), 0);
        sweep("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic ADD
        load_reg(1, 8'h05);
        load_reg(2, 8'h03);
        do_cmd(ADD, 1, 2, 0, 1'b0);
        chk("add data", int'(l_data), 8'h08);
        chk("add zero", int'(l_zero), 0);
        chk("add carry", int'(l_carry), 0);
        chk_dbg(1, 8'h08);

        // Carry and borrow
        load_reg(1, 8'hF0);
        load_reg(2, 8'h20);
        do_cmd(ADD, 1, 2, 0, 1'b0);
        chk("add ovf data", int'(l_data), 8'h10);
        chk("add ovf carry", int'(l_carry), 1);
        do_cmd(SUB, 2, 1, 0, 1'b0);
        chk("sub data", int'(l_data), 8'h10);
        chk("sub carry", int'(l_carry), 0);
        load_reg(2, 8'h20);
        do_cmd(SUB, 1, 2, 0, 1'b0);
        chk("sub borrow data", int'(l_data), 8'hF0);
        chk("sub borrow carry", int'(l_carry), 1);

        // SWAP
        load_reg(3, 8'hAA);
        load_reg(4, 8'h55);
        do_cmd(SWAP, 3, 4, 0, 1'b0);
        chk("swap data", int'(l_data), 8'h55);
        chk_dbg(3, 8'h55);
        chk_dbg(4, 8'hAA);
        load_reg(6, 8'h3C);
        do_cmd(SWAP, 6, 6, 0, 1'b0);
        chk("swap same data", int'(l_data), 8'h3C);
        chk_dbg(6, 8'h3C);

        // R0 rule and ONE wrap
        do_cmd(ONE, 0, 0, 0, 1'b0);
        chk("one r0 data", int'(l_data), 8'h01);
        chk_dbg(0, 8'h00);
        load_reg(5, 8'hFF);
        do_cmd(ONE, 5, 0, 0, 1'b0);
        chk("one wrap data", int'(l_data), 8'h00);
        chk("one wrap zero", int'(l_zero), 1);
        chk("one wrap carry", int'(l_carry), 1);

        // Backpressure with a competing command offered during RESP
        do_cmd(ADD, 2, 3, 5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        sweep("after hold");

        // Randomized commands with random response backpressure
        for (int n = 0; n < 80; n++)
            do_cmd(2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), 1'b0);
        sweep("random");

        // Reset while in EXEC
        load_reg(1, 8'h11);
        cmd_valid = 1'b1; cmd_op = ADD; cmd_addr_a = 3'd1; cmd_addr_b = 3'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("exec busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        chk("abort rsp_valid", int'(rsp_valid), 0);
        chk("abort cmd_ready", int'(cmd_ready), 1);
        sweep("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post-abort rsp_valid", int'(rsp_valid), 0);
            chk("post-abort cmd_ready", int'(cmd_ready), 1);
        end
        do_cmd(ONE, 1, 2, 0, 1'b0);
        chk("post-abort one", int'(l_data), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
